joy_dir_filter: RTL and testbench

Parametrised multi-channel joystick direction conditioner between `hps_io` joystick outputs and core input ports. Each channel debounces its four direction bits and cancels opposing directions (SOCD neutral). It then applies a run-time selectable restriction mode: 8-way pass-through, 4-way last-pressed, 4-way first-pressed, or 2-way horizontal. It replaces per-player single-mode filter instances and adds debounce, mode switching and change strobes.

---
 rtl/joy_dir_filter.sv | 205 ++++++++++++++++++++
 tb/tb_joy_dir_filter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/joy_dir_filter.sv
// joy_dir_filter: multi-channel joystick direction conditioner.
// Each channel debounces its four direction bits {up,down,left,right},
// neutralises opposing pairs (SOCD), then applies a shared restriction
// mode: 8-way pass-through, 4-way last-pressed, 4-way first-pressed or
// 2-way horizontal. A one-clock `changed` strobe follows every update
// of a channel's output register.
module joy_dir_filter #(
  parameter int CHANNELS = 2,
  parameter int DB_W     = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic [1:0]            mode,
  input  logic [4*CHANNELS-1:0] indir,
  output logic [4*CHANNELS-1:0] outdir,
  output logic [CHANNELS-1:0]   changed
);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_LAST  = 2'b01,
    MODE_FIRST = 2'b10,
    MODE_HORIZ = 2'b11
  } mode_e;

  localparam logic [DB_W-1:0] DB_MAX   = {DB_W{1'b1}};
  localparam logic [DB_W-1:0] CNT_ZERO = {DB_W{1'b0}};
  localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1'b1);
  localparam logic [3:0]      MASK_ALL = 4'b1111;
  localparam logic [3:0]      DIR_NONE = 4'b0000;

  // One-hot of the highest-priority set direction (up > down > left > right).
  function automatic logic [3:0] prio_onehot(input logic [3:0] x);
    logic [3:0] r;
    if (x[3]) begin
      r = 4'b1000;
    end else if (x[2]) begin
      r = 4'b0100;
    end else if (x[1]) begin
      r = 4'b0010;
    end else if (x[0]) begin
      r = 4'b0001;
    end else begin
      r = 4'b0000;
    end
    return r;
  endfunction

  // SOCD neutral: an opposing pair pressed together reads as neither.
  function automatic logic [3:0] socd_clean(input logic [3:0] d);
    logic [3:0] r;
    r = d;
    if (d[3] && d[2]) begin
      r[3:2] = 2'b00;
    end else begin
      r[3:2] = d[3:2];
    end
    if (d[1] && d[0]) begin
      r[1:0] = 2'b00;
    end else begin
      r[1:0] = d[1:0];
    end
    return r;
  endfunction

  logic [1:0] mode_q_r;
  logic       mode_chg_s;

  assign mode_chg_s = (mode != mode_q_r);

  // Registered copy of the mode, used to detect a mode switch on a ce tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q_r <= MODE_PASS;
    end else if (ce) begin
      mode_q_r <= mode;
    end else begin
      mode_q_r <= mode_q_r;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [3:0]            raw_s;
    logic [3:0]            db_r;
    logic [3:0]            db_next_s;
    logic [3:0][DB_W-1:0]  cnt_r;
    logic [3:0][DB_W-1:0]  cnt_next_s;
    logic [3:0]            c_s;
    logic [3:0]            new_s;
    logic [3:0]            fb_s;
    logic [3:0]            mask_r;
    logic [3:0]            mask_next_s;
    logic [3:0]            sel_mask_s;
    logic [3:0]            prev_r;
    logic [3:0]            prev_next_s;
    logic [3:0]            out_r;
    logic [3:0]            out_next_s;
    logic                  chg_r;

    assign raw_s = indir[4*ch +: 4];

    // Per-bit debounce: accept a new level only after DB_MAX+1 differing ticks.
    always_comb begin
      db_next_s  = db_r;
      cnt_next_s = cnt_r;
      for (int b = 0; b < 4; b++) begin
        if (raw_s[b] == db_r[b]) begin
          cnt_next_s[b] = CNT_ZERO;
        end else if (cnt_r[b] == DB_MAX) begin
          db_next_s[b]  = raw_s[b];
          cnt_next_s[b] = CNT_ZERO;
        end else begin
          cnt_next_s[b] = cnt_r[b] + CNT_ONE;
        end
      end
    end

    // Debounce state registers, advanced only on ce.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        db_r  <= DIR_NONE;
        cnt_r <= '{default: CNT_ZERO};
      end else if (ce) begin
        db_r  <= db_next_s;
        cnt_r <= cnt_next_s;
      end else begin
        db_r  <= db_r;
        cnt_r <= cnt_r;
      end
    end

    // Restriction logic: SOCD clean, press edges, mask update and output select.
    always_comb begin
      c_s         = socd_clean(db_r);
      new_s       = c_s & ~prev_r;
      fb_s        = (c_s != DIR_NONE) ? prio_onehot(c_s) : MASK_ALL;
      mask_next_s = MASK_ALL;
      prev_next_s = mode_chg_s ? DIR_NONE : c_s;
      if (mode_chg_s) begin
        mask_next_s = MASK_ALL;
      end else begin
        case (mode)
          MODE_LAST: begin
            if (new_s != DIR_NONE) begin
              mask_next_s = prio_onehot(new_s);
            end else if ((mask_r == MASK_ALL) || ((c_s & mask_r) == DIR_NONE)) begin
              mask_next_s = fb_s;
            end else begin
              mask_next_s = mask_r;
            end
          end
          MODE_FIRST: begin
            if ((mask_r == MASK_ALL) || ((c_s & mask_r) == DIR_NONE)) begin
              mask_next_s = fb_s;
            end else begin
              mask_next_s = mask_r;
            end
          end
          default: begin
            mask_next_s = MASK_ALL;
          end
        endcase
      end
      // An open mask with directions held only occurs on a mode-switch tick;
      // the fallback keeps 4-way modes at a single direction on that tick.
      if (mask_next_s == MASK_ALL) begin
        sel_mask_s = fb_s;
      end else begin
        sel_mask_s = mask_next_s;
      end
      case (mode)
        MODE_PASS:  out_next_s = c_s;
        MODE_LAST:  out_next_s = c_s & sel_mask_s;
        MODE_FIRST: out_next_s = c_s & sel_mask_s;
        MODE_HORIZ: out_next_s = {2'b00, c_s[1:0]};
        default:    out_next_s = c_s;
      endcase
    end

    // Edge history, mask, output register and change strobe.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        prev_r <= DIR_NONE;
        mask_r <= MASK_ALL;
        out_r  <= DIR_NONE;
        chg_r  <= 1'b0;
      end else if (ce) begin
        prev_r <= prev_next_s;
        mask_r <= mask_next_s;
        out_r  <= out_next_s;
        chg_r  <= (out_next_s != out_r);
      end else begin
        prev_r <= prev_r;
        mask_r <= mask_r;
        out_r  <= out_r;
        chg_r  <= 1'b0;
      end
    end

    assign outdir[4*ch +: 4] = out_r;
    assign changed[ch]       = chg_r;
  end

endmodule

// File: tb/tb_joy_dir_filter.sv
// tb_joy_dir_filter: directed scenarios plus randomized stimulus, every cycle
// compared against a behavioural model that tracks the selected direction
// as an index rather than a mask.
module tb_joy_dir_filter;

  localparam int CH    = 2;
  localparam int DBW   = 2;
  localparam int DBMAX = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ce;
  logic [1:0]    mode;
  logic [4*CH-1:0] indir;
  logic [4*CH-1:0] outdir;
  logic [CH-1:0]   changed;

  always #5 clk = ~clk;

  joy_dir_filter #(.CHANNELS(CH), .DB_W(DBW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .mode    (mode),
    .indir   (indir),
    .outdir  (outdir),
    .changed (changed)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [3:0] m_db   [CH];
  int         m_run  [CH][4];
  logic [3:0] m_prev [CH];
  int         m_sel  [CH];
  logic [3:0] m_out  [CH];
  logic       m_chg  [CH];
  logic [1:0] m_mode_q;

  function automatic int top_dir(input logic [3:0] x);
    for (int i = 3; i >= 0; i--) begin
      if (x[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < CH; ch++) begin
      m_db[ch] = 4'b0000;
      m_prev[ch] = 4'b0000;
      m_sel[ch] = -1;
      m_out[ch] = 4'b0000;
      m_chg[ch] = 1'b0;
      for (int b = 0; b < 4; b++) m_run[ch][b] = 0;
    end
    m_mode_q = 2'b00;
  endtask

  task automatic model_tick(input logic ce_v, input logic [1:0] mode_v, input logic [4*CH-1:0] raw_v);
    bit switched;
    if (!ce_v) begin
      for (int ch = 0; ch < CH; ch++) m_chg[ch] = 1'b0;
      return;
    end
    switched = (mode_v != m_mode_q);
    for (int ch = 0; ch < CH; ch++) begin
      logic [3:0] c, pressed, raw, nxt;
      int s;
      c = m_db[ch];
      if (c[3] && c[2]) c[3:2] = 2'b00;
      if (c[1] && c[0]) c[1:0] = 2'b00;
      pressed = c & ~m_prev[ch];
      if (switched) begin
        m_sel[ch] = -1;
      end else if (mode_v == 2'd1) begin
        if (pressed != 4'b0000) m_sel[ch] = top_dir(pressed);
        else if (m_sel[ch] < 0 || !c[m_sel[ch]]) m_sel[ch] = top_dir(c);
      end else if (mode_v == 2'd2) begin
        if (m_sel[ch] < 0 || !c[m_sel[ch]]) m_sel[ch] = top_dir(c);
      end else begin
        m_sel[ch] = -1;
      end
      case (mode_v)
        2'd0: nxt = c;
        2'd3: nxt = {2'b00, c[1:0]};
        default: begin
          s = (m_sel[ch] >= 0) ? m_sel[ch] : top_dir(c);
          nxt = (s >= 0) ? (4'b0001 << s) : 4'b0000;
        end
      endcase
      m_prev[ch] = switched ? 4'b0000 : c;
      raw = raw_v[4*ch +: 4];
      for (int b = 0; b < 4; b++) begin
        if (raw[b] != m_db[ch][b]) begin
          m_run[ch][b]++;
          if (m_run[ch][b] > DBMAX) begin
            m_db[ch][b] = raw[b];
            m_run[ch][b] = 0;
          end
        end else begin
          m_run[ch][b] = 0;
        end
      end
      m_chg[ch] = (nxt != m_out[ch]);
      m_out[ch] = nxt;
    end
    m_mode_q = mode_v;
  endtask

  task automatic check_all();
    for (int ch = 0; ch < CH; ch++) begin
      check_eq($sformatf("outdir_ch%0d", ch), 32'(outdir[4*ch +: 4]), 32'(m_out[ch]));
      check_eq($sformatf("changed_ch%0d", ch), 32'(changed[ch]), 32'(m_chg[ch]));
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (reset_n) model_tick(ce, mode, indir);
      #1;
      check_all();
    end
  endtask

  task automatic pulse_reset();
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check_eq("rst_async_out", 32'(outdir), 32'd0);
    check_eq("rst_async_chg", 32'(changed), 32'd0);
    @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;
  endtask

  initial begin
    int hold [CH];
    reset_n = 1'b0;
    ce      = 1'b0;
    mode    = 2'b00;
    indir   = '0;
    model_reset();
    #3;
    check_eq("rst_outdir", 32'(outdir), 32'd0);
    check_eq("rst_changed", 32'(changed), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ce      = 1'b1;

    // Debounce latency and glitch rejection, mode 00
    indir = 8'h02;
    step(4);
    check_eq("db_tick4", 32'(outdir[3:0]), 32'h0);
    step(1);
    check_eq("db_tick5", 32'(outdir[3:0]), 32'h2);
    check_eq("db_chg", 32'(changed[0]), 32'd1);
    step(1);
    check_eq("db_chg_drop", 32'(changed[0]), 32'd0);
    indir = 8'h01;
    step(3);
    indir = 8'h02;
    step(6);
    check_eq("glitch_hold", 32'(outdir[3:0]), 32'h2);

    // SOCD and diagonal pass-through
    indir = 8'h0F;
    step(6);
    check_eq("socd_all", 32'(outdir[3:0]), 32'h0);
    indir = 8'h0A;
    step(6);
    check_eq("diag_pass", 32'(outdir[3:0]), 32'hA);

    // Mode 01: last pressed wins
    mode = 2'b01;
    indir = 8'h00;
    step(6);
    indir = 8'h02;
    step(6);
    check_eq("last_left", 32'(outdir[3:0]), 32'h2);
    indir = 8'h0A;
    step(6);
    check_eq("last_up", 32'(outdir[3:0]), 32'h8);
    indir = 8'h02;
    step(6);
    check_eq("last_rel_up", 32'(outdir[3:0]), 32'h2);
    indir = 8'h00;
    step(6);
    check_eq("last_rel_all", 32'(outdir[3:0]), 32'h0);

    // Mode 10: first pressed holds
    mode = 2'b10;
    indir = 8'h01;
    step(6);
    check_eq("first_right", 32'(outdir[3:0]), 32'h1);
    indir = 8'h05;
    step(6);
    check_eq("first_hold", 32'(outdir[3:0]), 32'h1);
    indir = 8'h04;
    step(6);
    check_eq("first_fallback", 32'(outdir[3:0]), 32'h4);
    indir = 8'h00;
    step(6);

    // Mode 11 then switch to 01 with a diagonal held
    mode = 2'b11;
    indir = 8'h09;
    step(6);
    check_eq("horiz", 32'(outdir[3:0]), 32'h1);
    mode = 2'b01;
    step(1);
    check_eq("switch_out", 32'(outdir[3:0]), 32'h8);
    check_eq("switch_chg", 32'(changed[0]), 32'd1);
    step(1);
    check_eq("switch_settle", 32'(outdir[3:0]), 32'h8);

    // Two channels, reset mid-hold
    mode = 2'b00;
    indir = 8'h5A;
    step(6);
    check_eq("two_ch", 32'(outdir), 32'h5A);
    indir = 8'h31;
    step(2);
    pulse_reset();
    step(1);
    check_eq("post_rst_chg", 32'(changed), 32'd0);

    // ce held low freezes everything
    indir = 8'h5A;
    step(6);
    ce = 1'b0;
    for (int i = 0; i < 8; i++) begin
      indir = 8'($urandom);
      step(1);
      check_eq("ce0_frozen", 32'(outdir), 32'h5A);
      check_eq("ce0_nochg", 32'(changed), 32'd0);
    end
    ce = 1'b1;

    // Randomized phase
    for (int ch = 0; ch < CH; ch++) hold[ch] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int ch = 0; ch < CH; ch++) begin
        if (hold[ch] == 0) begin
          indir[4*ch +: 4] = 4'($urandom_range(0, 15));
          hold[ch] = $urandom_range(1, 9);
        end else begin
          hold[ch]--;
        end
      end
      ce = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 79) == 0) mode = 2'($urandom_range(0, 3));
      step(1);
      if ($urandom_range(0, 599) == 0) pulse_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
